// File: rtl/acc20_seq_unit.sv
// acc20_seq_unit: sequential 20-bit two's-complement accumulator with a
// valid/ready request side and a valid/ready result side.
// Arithmetic matches the 20-bit ripple add/subtract datapath: SUB is
// A + ~B + 1, and ovf is the carry into bit 19 XOR the carry out of bit 19.
//
// Build option: define ACC20_SATURATE_EN to clamp acc on signed overflow
// (0x7FFFF on positive overflow, 0x80000 on negative overflow).
// carry, ovf, ovf_sticky and op_count are identical in both builds.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid; captures op and operand
// EXEC  | single cycle; updates acc, flags and op_count
// RESP  | out_valid=1, outputs frozen until out_ready

module acc20_seq_unit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [19:0]      operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [19:0]      acc,
   output logic             carry,
   output logic             ovf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t      state;
   logic [1:0]  op_q;
   logic [19:0] operand_q;

   logic [19:0] b_eff;
   logic        cin;
   logic [20:0] sum_full;
   logic [19:0] sum_wrap;
   logic        c19;
   logic        c18;
   logic        ovf_n;
   logic [19:0] acc_arith;

   // Ripple-equivalent add/subtract of acc and the captured operand.
   always_comb begin
      cin       = (op_q == OP_SUB);
      b_eff     = cin ? ~operand_q : operand_q;
      sum_full  = {1'b0, acc} + {1'b0, b_eff} + {20'b0, cin};
      sum_wrap  = sum_full[19:0];
      c19       = sum_full[20];
      // carry into bit 19 recovered from the bit-19 sum and its inputs
      c18       = acc[19] ^ b_eff[19] ^ sum_wrap[19];
      ovf_n     = c18 ^ c19;
`ifdef ACC20_SATURATE_EN
      if (ovf_n) begin
         acc_arith = sum_wrap[19] ? 20'h7FFFF : 20'h80000;
      end else begin
         acc_arith = sum_wrap;
      end
`else
      acc_arith = sum_wrap;
`endif
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         op_q       <= OP_LOAD;
         operand_q  <= 20'h0;
         acc        <= 20'h0;
         carry      <= 1'b0;
         ovf        <= 1'b0;
         ovf_sticky <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q      <= op;
                  operand_q <= operand;
                  in_ready  <= 1'b0;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_LOAD: begin
                     acc      <= operand_q;
                     carry    <= 1'b0;
                     ovf      <= 1'b0;
                     op_count <= op_count + CNT_W'(1);
                  end
                  OP_ADD, OP_SUB: begin
                     acc      <= acc_arith;
                     carry    <= c19;
                     ovf      <= ovf_n;
                     op_count <= op_count + CNT_W'(1);
                     if (ovf_n) begin
                        ovf_sticky <= 1'b1;
                     end
                  end
                  default: begin
                     acc        <= 20'h0;
                     carry      <= 1'b0;
                     ovf        <= 1'b0;
                     ovf_sticky <= 1'b0;
                     op_count   <= '0;
                  end
               endcase
               out_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
